// File: rtl/sram_lat.sv
// Single-port word SRAM behind a valid/ready request/response handshake with programmable latency.
// Optional macro SRAM_LAT_RAND_EN adds an 8-bit LFSR that randomises per-request latency in 1..LATENCY.
module sram_lat #(
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wen,
    input  logic [31:0]       req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [DATA_W/8-1:0] req_wmask,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_wr
);

    localparam int NB    = DATA_W / 8;
    localparam int OFF_W = $clog2(NB);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(LATENCY + 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              wen_q, wen_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [NB-1:0]     wmask_q, wmask_d;
    logic [DATA_W-1:0] rdata_q;
    logic              wr_q;
    logic              enter_resp;
    logic [CNT_W-1:0]  lat_eff;
    logic              unused_addr;

    logic [DATA_W-1:0] mem [DEPTH];

    assign unused_addr = ^req_addr;

`ifdef SRAM_LAT_RAND_EN
    logic [7:0] lfsr_q;

    // Fibonacci form of x^8+x^6+x^5+x^4+1, free-running.
    always_ff @(posedge clk) begin
        if (!rst) begin
            lfsr_q <= 8'hA5;
        end else begin
            lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        end
    end

    assign lat_eff = CNT_W'(32'd1 + (32'(lfsr_q) % 32'(LATENCY)));
`else
    assign lat_eff = CNT_W'(LATENCY);
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        wen_d      = wen_q;
        idx_d      = idx_q;
        wdata_d    = wdata_q;
        wmask_d    = wmask_q;
        enter_resp = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    wen_d   = req_wen;
                    idx_d   = req_addr[OFF_W +: IDX_W];
                    wdata_d = req_wdata;
                    wmask_d = req_wmask;
                    if (lat_eff == CNT_W'(1)) begin
                        state_d    = ST_RESP;
                        enter_resp = 1'b1;
                        cnt_d      = '0;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = lat_eff - CNT_W'(1);
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == CNT_W'(1)) begin
                    state_d    = ST_RESP;
                    enter_resp = 1'b1;
                    cnt_d      = '0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_RESP: begin
                if (resp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            wen_q   <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            wmask_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wen_q   <= wen_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            wmask_q <= wmask_d;
        end
    end

    // The _d payload is used so a single-cycle request hits the array on its accept edge.
    always_ff @(posedge clk) begin
        if (rst && enter_resp && wen_d) begin
            for (int b = 0; b < NB; b++) begin
                if (wmask_d[b]) begin
                    mem[idx_d][8*b +: 8] <= wdata_d[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rdata_q <= '0;
            wr_q    <= 1'b0;
        end else if (enter_resp) begin
            wr_q    <= wen_d;
            rdata_q <= wen_d ? '0 : mem[idx_d];
        end
    end

    assign req_ready  = (state_q == ST_IDLE);
    assign resp_valid = (state_q == ST_RESP);
    assign resp_rdata = rdata_q;
    assign resp_wr    = wr_q;

endmodule

// File: doc/sram_lat.md
SRAM_LAT -- requirements
Module: sram_lat

Interface
REQ-001 Parameter DATA_W, default 32, data word width in bits; SHALL be a power of two, at least 8.
REQ-002 Parameter DEPTH, default 1024, number of words in the internal array; SHALL be a power of two.
REQ-003 Parameter LATENCY, default 1, request-accept to response-valid delay in cycles; SHALL be at least 1.
REQ-004 Port clk, input, 1, single clock; all state changes on its rising edge.
REQ-005 Port rst, input, 1, reset; synchronous, active-low.
REQ-006 Port req_valid, input, 1, request present.
REQ-007 Port req_ready, output, 1, block accepts a request this cycle.
REQ-008 Port req_wen, input, 1, 1 = write, 0 = read.
REQ-009 Port req_addr, input, 32, byte address.
REQ-010 Port req_wdata, input, DATA_W, write data.
REQ-011 Port req_wmask, input, DATA_W/8, byte-lane write enables; bit i covers bits 8i+7..8i.
REQ-012 Port resp_valid, output, 1, response present.
REQ-013 Port resp_ready, input, 1, consumer accepts the response.
REQ-014 Port resp_rdata, output, DATA_W, read data; zero for write responses.
REQ-015 Port resp_wr, output, 1, 1 = response acknowledges a write.

Function
REQ-016 FSM states IDLE, WAIT, RESP; req_ready = 1 only in IDLE; resp_valid = 1 only in RESP.
REQ-017 Accept = req_valid & req_ready; on accept, latch wen, word index, wdata and wmask, and load the latency counter.
REQ-018 Word index = req_addr bits [log2(DATA_W/8) + log2(DEPTH) - 1 : log2(DATA_W/8)]; higher address bits are ignored, so addresses wrap modulo DEPTH words.
REQ-019 Low byte-offset bits of req_addr are ignored; unaligned accesses are treated as aligned.
REQ-020 Effective latency L: LATENCY goes IDLE -> RESP when L = 1; otherwise IDLE -> WAIT, staying in WAIT L-1 cycles, so resp_valid first rises exactly L cycles after the accept edge.
REQ-021 On entry to RESP, a read registers array[index] into resp_rdata; a write updates only the masked bytes of array[index] and drives resp_rdata = 0.
REQ-022 A write with all-zero wmask is acknowledged normally and leaves the array unchanged.
REQ-023 In RESP, resp_valid, resp_rdata and resp_wr are held stable until resp_ready = 1; on that edge the FSM returns to IDLE.
REQ-024 The block has one outstanding request at most; the earliest next accept is the cycle after the response handshake.
REQ-025 resp_ready while not in RESP has no effect; req_valid while not in IDLE is ignored and not queued.
REQ-026 A read issued after a write to the same word returns the written data; there are no stale reads.

Reset
REQ-027 rst = 0 at a clock edge forces IDLE, counter = 0, resp_rdata = 0 and resp_wr = 0; after reset, req_ready = 1 and resp_valid = 0.
REQ-028 Reset mid-operation discards the in-flight request; a pending write that has not reached RESP SHALL NOT modify the array.
REQ-029 Array contents are not cleared by reset.

Configuration
REQ-030 Macro SRAM_LAT_RAND_EN: when defined, an 8-bit LFSR is included.
REQ-031 The LFSR uses polynomial x^8+x^6+x^5+x^4+1, is seeded to 8'hA5 on reset, and advances every cycle.
REQ-032 With SRAM_LAT_RAND_EN, L = 1 + (LFSR value mod LATENCY), sampled on the accept edge.
REQ-033 Without SRAM_LAT_RAND_EN, L = LATENCY for every request and no LFSR logic exists.

Verification
REQ-034 LATENCY = 3: write addr 0x10, data 0xDEADBEEF, mask 4'hF accepted at cycle 0 -> resp_valid at cycle 3 with resp_wr = 1; then read addr 0x10 -> resp_rdata = 0xDEADBEEF, resp_wr = 0.
REQ-035 Word 0x20 holds 0x11223344; write 0xAABBCCDD with mask 4'b0101 -> subsequent read returns 0x11BB33DD.
REQ-036 DEPTH = 1024: write 0x55 to addr 0x1000 -> read of addr 0x0 returns 0x55 (wrap).
REQ-037 Hold resp_ready = 0 for 5 cycles in RESP -> resp_valid and resp_rdata stay stable; req_valid pulses during RESP are not accepted.
REQ-038 Assert rst = 0 during WAIT of a write to addr 0x40 -> next cycle IDLE with resp_valid = 0; a later read of 0x40 returns the old value.
REQ-039 With SRAM_LAT_RAND_EN and LATENCY = 4, run 200 requests -> every observed latency is in 1..4 and all four values occur.
